// File: rtl/seg_display_mux.sv
`default_nettype none
// seg_display_mux: time-multiplexed hex 7-segment driver with a load-captured shadow register,
// anti-ghost digit blanking and a frame pulse. Define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [6:0] SEGS_OFF = {7{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};

  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    blank;
  logic                    last_slot;
  logic                    last_dig;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                    upper_nz;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1100111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    segs_d       = SEGS_OFF;
    dp_d         = POL;
    an_d         = AN_OFF;
    frame_done_d = 1'b0;
    nib_sel      = 4'h0;
    dp_sel       = 1'b0;
    onehot       = '0;
    blank        = 1'b0;
    last_slot    = (cnt_q == CW'(CLK_DIV - 1));
    last_dig     = (idx_q == IW'(NUM_DIGITS - 1));

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib_sel   = shadow_val_q[4*i +: 4];
        dp_sel    = shadow_dp_q[i];
        onehot[i] = 1'b1;
      end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more significant nibble are zero; digit 0 always shows.
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (shadow_val_q[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    blank = (idx_q != '0) && !upper_nz;
`endif

    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end

    if (enable) begin
      cnt_d = last_slot ? '0 : cnt_q + CW'(1);
      if (last_slot) idx_d = last_dig ? '0 : idx_q + IW'(1);
      frame_done_d = last_slot && last_dig;
      segs_d       = blank ? SEGS_OFF : (glyph(nib_sel) ^ SEGS_OFF);
      dp_d         = dp_sel ^ POL;
      // Slot count 0 keeps every anode off so the previous digit cannot ghost.
      an_d         = (cnt_q == '0) ? AN_OFF : (onehot ^ AN_OFF);
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      segs_q       <= SEGS_OFF;
      dp_q         <= POL;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      segs_q       <= segs_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segs       = segs_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_mux.sv
`default_nettype none
// tb_seg_display_mux: directed stimulus against a slot/digit arithmetic model, for both pin polarities.
module tb_seg_display_mux;

  localparam int N = 4;
  localparam int D = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        enable = 1'b0;

  logic [6:0]  segs0, segs1;
  logic        dp0, dp1, fd0, fd1;
  logic [3:0]  an0, an1;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  seg_display_mux #(.NUM_DIGITS(N), .CLK_DIV(D), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .segs(segs0), .dp(dp0), .an(an0), .frame_done(fd0)
  );

  seg_display_mux #(.NUM_DIGITS(N), .CLK_DIV(D), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .segs(segs1), .dp(dp1), .an(an1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
            7'b1111101, 7'b0000111, 7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
            7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    return tbl[h];
  endfunction

  // Model: m_t counts enabled cycles since the scan (re)started.
  int          m_t = 0;
  int          slot, dig;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [6:0]  e_segs = 7'h0;
  logic        e_dp = 1'b0;
  logic [3:0]  e_an = 4'h0;
  logic        e_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_val = 16'h0; m_dp = 4'h0;
      e_segs = 7'h0; e_dp = 1'b0; e_an = 4'h0; e_fd = 1'b0;
    end else begin
      if (!enable) begin
        m_t = 0;
        e_segs = 7'h0; e_dp = 1'b0; e_an = 4'h0; e_fd = 1'b0;
      end else begin
        slot   = m_t % D;
        dig    = (m_t / D) % N;
        e_an   = (slot == 0) ? 4'h0 : 4'(1 << dig);
        e_segs = (BLANK_EN && dig > 0 && (m_val >> (4 * dig)) == 16'h0) ? 7'h0 : font(m_val[4*dig +: 4]);
        e_dp   = m_dp[dig];
        e_fd   = (m_t % (D * N)) == (D * N - 1);
        m_t++;
      end
      if (load) begin
        m_val = value;
        m_dp  = dp_in;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({fd0, an0, dp0, segs0} !== {e_fd, e_an, e_dp, e_segs}) begin
      errors++;
      $display("FAIL model_pol0 t=%0t got fd=%b an=%b dp=%b segs=%b expected fd=%b an=%b dp=%b segs=%b",
               $time, fd0, an0, dp0, segs0, e_fd, e_an, e_dp, e_segs);
    end
    checks++;
    if ({fd1, an1, dp1, segs1} !== {e_fd, ~e_an, ~e_dp, ~e_segs}) begin
      errors++;
      $display("FAIL model_pol1 t=%0t got fd=%b an=%b dp=%b segs=%b expected fd=%b an=%b dp=%b segs=%b",
               $time, fd1, an1, dp1, segs1, e_fd, ~e_an, ~e_dp, ~e_segs);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  task automatic goto_edge(input int k);
    if (k > ecount) step(k - ecount);
  endtask

  logic [15:0] vec_val [6] = '{16'hBEEF, 16'h0001, 16'h00C0, 16'h9000, 16'h0A0B, 16'h7654};
  logic [3:0]  vec_dp  [6] = '{4'h1, 4'h8, 4'h2, 4'hF, 4'h0, 4'h5};

  initial begin
    #1 rst_n = 1'b0;
    value = 16'h12AF; dp_in = 4'h0; load = 1'b1; enable = 1'b1;
    #2;
    check("reset_an0", 32'(an0), 32'h0);
    check("reset_segs0", 32'(segs0), 32'h0);
    check("reset_fd0", 32'(fd0), 32'h0);
    check("reset_an1", 32'(an1), 32'hF);
    check("reset_segs1_dp1", 32'({dp1, segs1}), 32'hFF);
    #9 rst_n = 1'b1;

    step(1);
    load = 1'b0;
    goto_edge(2);
    check("d0_an", 32'(an0), 32'h1);
    check("d0_segs_F", 32'(segs0), 32'b1110001);
    check("d0_an_pol1", 32'(an1), 32'b1110);
    check("d0_segs_pol1", 32'(segs1), 32'b0001110);
    goto_edge(5);
    check("slot0_dark", 32'(an0), 32'h0);
    goto_edge(6);
    check("d1_an", 32'(an0), 32'b0010);
    check("d1_segs_A", 32'(segs0), 32'b1110111);
    goto_edge(10);
    check("d2_an", 32'(an0), 32'b0100);
    check("d2_segs_2", 32'(segs0), 32'b1011011);
    goto_edge(14);
    check("d3_an", 32'(an0), 32'b1000);
    check("d3_segs_1", 32'(segs0), 32'b0000110);
    goto_edge(15);
    check("fd_before", 32'(fd0), 32'h0);
    goto_edge(16);
    check("fd_pulse", 32'(fd0), 32'h1);
    check("fd_pulse_pol1", 32'(fd1), 32'h1);
    goto_edge(17);
    check("fd_one_cycle", 32'(fd0), 32'h0);

    value = 16'h0000; load = 1'b1;
    goto_edge(18);
    load = 1'b0;
    goto_edge(34);
    check("zero_d0", 32'({an0, segs0}), 32'({4'b0001, 7'b0111111}));
    goto_edge(38);
    check("zero_d1", 32'({an0, segs0}), 32'({4'b0010, (BLANK_EN ? 7'h0 : 7'b0111111)}));

    value = 16'h0050; dp_in = 4'b0100; load = 1'b1;
    goto_edge(39);
    load = 1'b0;
    goto_edge(46);
    check("v50_d3", 32'({an0, dp0, segs0}), 32'({4'b1000, 1'b0, (BLANK_EN ? 7'h0 : 7'b0111111)}));
    goto_edge(50);
    check("v50_d0", 32'({an0, dp0, segs0}), 32'({4'b0001, 1'b0, 7'b0111111}));
    goto_edge(54);
    check("v50_d1", 32'({an0, dp0, segs0}), 32'({4'b0010, 1'b0, 7'b1101101}));
    goto_edge(58);
    check("v50_d2", 32'({an0, dp0, segs0}), 32'({4'b0100, 1'b1, (BLANK_EN ? 7'h0 : 7'b0111111)}));
    check("v50_d2_dp_pol1", 32'(dp1), 32'h0);

    goto_edge(74);
    enable = 1'b0;
    goto_edge(75);
    check("dis_an", 32'(an0), 32'h0);
    check("dis_fd", 32'(fd0), 32'h0);
    goto_edge(77);
    enable = 1'b1;
    goto_edge(78);
    check("reen_dark", 32'(an0), 32'h0);
    goto_edge(79);
    check("reen_d0", 32'(an0), 32'b0001);

    goto_edge(85);
    #2 rst_n = 1'b0;
    #1;
    check("async_an0", 32'(an0), 32'h0);
    check("async_segs0", 32'({fd0, dp0, segs0}), 32'h0);
    check("async_an1", 32'(an1), 32'hF);
    #8 rst_n = 1'b1;
    ecount = 0;
    goto_edge(2);
    check("rst_d0", 32'({an0, segs0}), 32'({4'b0001, 7'b0111111}));
    goto_edge(6);
    check("rst_d1", 32'({an0, segs0}), 32'({4'b0010, (BLANK_EN ? 7'h0 : 7'b0111111)}));

    for (int v = 0; v < 6; v++) begin
      value = vec_val[v]; dp_in = vec_dp[v]; load = 1'b1;
      step(1);
      load = 1'b0;
      if (v == 3) begin
        step(7);
        enable = 1'b0;
        step(2);
        enable = 1'b1;
      end
      step(18);
    end

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
